// File: rtl/rtc_access_arbiter_if.sv
// Bundle of requester, engine and status signals around the RTC access arbiter.
// master = requesters/engine side, slave = arbiter side.
interface rtc_access_arbiter_if;
  logic [2:0] REQ;
  logic [6:0] DIR_RD;
  logic [6:0] DIR_WR;
  logic [7:0] DAT_WR;
  logic [6:0] DIR_ST;
  logic [7:0] DAT_ST;
  logic       FRW;
  logic [7:0] DIN;
  logic [2:0] GNT;
  logic [2:0] DONE;
  logic       Acceso;
  logic       Mod;
  logic [6:0] Dir;
  logic [7:0] DOUT;
  logic [7:0] RD_DATA;
  logic       BUSY;
  logic       ERR;

  modport master (
    output REQ, DIR_RD, DIR_WR, DAT_WR, DIR_ST, DAT_ST, FRW, DIN,
    input  GNT, DONE, Acceso, Mod, Dir, DOUT, RD_DATA, BUSY, ERR
  );

  modport slave (
    input  REQ, DIR_RD, DIR_WR, DAT_WR, DIR_ST, DAT_ST, FRW, DIN,
    output GNT, DONE, Acceso, Mod, Dir, DOUT, RD_DATA, BUSY, ERR
  );
endinterface

// File: rtl/rtc_access_arbiter.sv
// Shares one RTC read/write engine between menu sweep, user write and status-clear requesters.
// Optional WAIT timeout with ERR pulse is enabled by defining RTC_ARB_TIMEOUT_EN.
module rtc_access_arbiter #(
  parameter int STARVE_MAX = 4
`ifdef RTC_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input logic                 CLK,
  input logic                 RST_N,
  rtc_access_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic          mod_q, mod_d;
  logic [6:0]    dir_q, dir_d;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [2:0]    sel;
`ifdef RTC_ARB_TIMEOUT_EN
  logic [7:0]    tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    mod_d     = mod_q;
    dir_d     = dir_q;
    dout_d    = dout_q;
    rd_data_d = rd_data_q;
    starve_d  = starve_q;
    sel       = 3'b000;
`ifdef RTC_ARB_TIMEOUT_EN
    tmo_d     = tmo_q;
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|bus.REQ) begin
          // a starved menu sweep overrides the fixed priority for one arbitration
          if (bus.REQ[0] && (starve_q == STARVE_LIM)) sel = 3'b001;
          else if (bus.REQ[2])                        sel = 3'b100;
          else if (bus.REQ[1])                        sel = 3'b010;
          else                                        sel = 3'b001;
          gnt_d   = sel;
          state_d = S_ISSUE;
          case (sel)
            3'b100: begin
              mod_d  = 1'b1;
              dir_d  = bus.DIR_ST;
              dout_d = bus.DAT_ST;
            end
            3'b010: begin
              mod_d  = 1'b1;
              dir_d  = bus.DIR_WR;
              dout_d = bus.DAT_WR;
            end
            default: begin
              mod_d  = 1'b0;
              dir_d  = bus.DIR_RD;
              dout_d = 8'h00;
            end
          endcase
          if (sel[0])
            starve_d = '0;
          else if (bus.REQ[0] && (starve_q != STARVE_LIM))
            starve_d = starve_q + 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef RTC_ARB_TIMEOUT_EN
        tmo_d   = 8'd0;
`endif
      end
      S_WAIT: begin
        if (bus.FRW) begin
          state_d = S_DONE;
          if (!mod_q) rd_data_d = bus.DIN;
        end
`ifdef RTC_ARB_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_d == 8'(TIMEOUT_CYC)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = 3'b000;
        mod_d   = 1'b0;
        dout_d  = 8'h00;
`ifdef RTC_ARB_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // a dropped menu request forfeits its accumulated starvation credit
    if (!bus.REQ[0]) starve_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      gnt_q     <= 3'b000;
      mod_q     <= 1'b0;
      dir_q     <= 7'h00;
      dout_q    <= 8'h00;
      rd_data_q <= 8'h00;
      starve_q  <= '0;
`ifdef RTC_ARB_TIMEOUT_EN
      tmo_q     <= 8'd0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      mod_q     <= mod_d;
      dir_q     <= dir_d;
      dout_q    <= dout_d;
      rd_data_q <= rd_data_d;
      starve_q  <= starve_d;
`ifdef RTC_ARB_TIMEOUT_EN
      tmo_q     <= tmo_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bus.GNT     = gnt_q;
  assign bus.DONE    = (state_q == S_DONE) ? gnt_q : 3'b000;
  assign bus.Acceso  = (state_q == S_ISSUE);
  assign bus.Mod     = mod_q;
  assign bus.Dir     = dir_q;
  assign bus.DOUT    = dout_q;
  assign bus.RD_DATA = rd_data_q;
  assign bus.BUSY    = (state_q != S_IDLE);
`ifdef RTC_ARB_TIMEOUT_EN
  assign bus.ERR     = err_q;
`else
  assign bus.ERR     = 1'b0;
`endif

endmodule
